vga_timing_gen: RTL and testbench

- Generates 640x480 @ 60 Hz VGA raster timing from a 25 MHz pixel clock.
- Drives `col`/`row` to the combinational pixel generators: status bar, playfield, sprites. Their summed RGB comes back to this block.
- Registers that RGB together with the delayed sync/blank signals, so the pins see colour and sync aligned.
- Sits between the pixel generators and the DAC pins (VGA_*).

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen_mod_counter.sv | 37 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 raster,
// derived totals and sync windows, and datapath widths.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 8;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOT = H_VISIBLE_DEF + H_FRONT_DEF
                       + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOT = V_VISIBLE_DEF + V_FRONT_DEF
                       + V_SYNC_DEF + V_BACK_DEF;

  localparam int HS_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator, the pixel
// generators and the DAC pins.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [COLOR_W-1:0] rgb_r;
  logic [COLOR_W-1:0] rgb_g;
  logic [COLOR_W-1:0] rgb_b;
  logic [CNT_W-1:0]   col;
  logic [CNT_W-1:0]   row;
  logic               video_on;
  logic               frame_start;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;
  logic               VGA_SYNC_N;

  modport master (
    input  rgb_r, rgb_g, rgb_b,
    output col, row, video_on, frame_start,
    output VGA_R, VGA_G, VGA_B,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
  );

  modport slave (
    output rgb_r, rgb_g, rgb_b,
    input  col, row, video_on, frame_start,
    input  VGA_R, VGA_G, VGA_B,
    input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
  );

endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MAX counter with enable; wrap_o flags the
// enabled step from MAX-1 back to 0.
module mod_counter #(
  parameter int MAX   = 800,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, derived sync/blank and a
// single output register aligning colour with sync at the pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input logic              clk_25mhz,
  input logic              rst,
  vga_timing_gen_if.master vga
);

  localparam int HT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSS = H_VISIBLE + H_FRONT;
  localparam int VSS = V_VISIBLE + V_FRONT;

  localparam logic [CNT_W-1:0] HV_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] VV_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HSS_C = CNT_W'(HSS);
  localparam logic [CNT_W-1:0] HSE_C = CNT_W'(HSS + H_SYNC);
  localparam logic [CNT_W-1:0] VSS_C = CNT_W'(VSS);
  localparam logic [CNT_W-1:0] VSE_C = CNT_W'(VSS + V_SYNC);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             hsync_c;
  logic             vsync_c;
  logic             von_c;

  mod_counter #(.MAX(HT), .WIDTH(CNT_W)) u_hcnt (
    .clk    (clk_25mhz),
    .rst    (rst),
    .en_i   (1'b1),
    .cnt_o  (h),
    .wrap_o (h_wrap)
  );

  mod_counter #(.MAX(VT), .WIDTH(CNT_W)) u_vcnt (
    .clk    (clk_25mhz),
    .rst    (rst),
    .en_i   (h_wrap),
    .cnt_o  (v),
    .wrap_o (v_wrap_unused)
  );

  assign von_c   = (h < HV_C) && (v < VV_C);
  assign hsync_c = !((h >= HSS_C) && (h < HSE_C));
  assign vsync_c = !((v >= VSS_C) && (v < VSE_C));

  assign vga.col         = h;
  assign vga.row         = v;
  assign vga.video_on    = von_c;
  assign vga.frame_start = (h == '0) && (v == '0);
  assign vga.VGA_SYNC_N  = 1'b0;

  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               hs_q, vs_q, blank_n_q;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (von_c) begin
      r_d = vga.rgb_r;
      g_d = vga.rgb_g;
      b_d = vga.rgb_b;
    end
  end

  // Colour and sync share one bank so both reach the pins together.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hsync_c;
      vs_q      <= vsync_c;
      blank_n_q <= von_c;
    end
  end

  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a reduced-timing and a default-timing instance checked
// each cycle against a cycle-count raster model.
module tb_vga_timing_gen;

  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 6;
  localparam int SVV = 20, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SFT = SHT * (SVV + SVF + SVS + SVB);

  localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;

  logic clk_25mhz = 1'b0;
  logic rst = 1'b1;

  always #20 clk_25mhz = ~clk_25mhz;

  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_d ();

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .vga       (if_s.master)
  );

  vga_timing_gen dut_d (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .vga       (if_d.master)
  );

  typedef struct {
    int col;
    int row;
    bit von;
    bit fs;
    bit hs;
    bit vs;
  } pix_t;

  int errs = 0;
  int checks = 0;
  int n = 0;
  logic [7:0] pr = '0, pg = '0, pb = '0;
  int fs_cnt = 0;
  int vs_run = 0;
  int vs_runs = 0;
  int hs_run = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s n=%0d got=%0h want=%0h", tag, n, act, exp);
    end
  endtask

  // Pixel shown by the counters after k clocks from reset release.
  function automatic pix_t pix(int k, int hv, int hf, int hsw, int hb,
                               int vv, int vf, int vsw, int vb);
    pix_t p;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    p.col = k % ht;
    p.row = (k / ht) % vt;
    p.von = (p.col < hv) && (p.row < vv);
    p.fs  = (p.col == 0) && (p.row == 0);
    p.hs  = !((p.col >= hv + hf) && (p.col < hv + hf + hsw));
    p.vs  = !((p.row >= vv + vf) && (p.row < vv + vf + vsw));
    return p;
  endfunction

  task automatic check_dut(string p,
                           int hv, int hf, int hsw, int hb,
                           int vv, int vf, int vsw, int vb,
                           logic [9:0] col, logic [9:0] row,
                           logic von, logic fs,
                           logic [7:0] r, logic [7:0] g, logic [7:0] b,
                           logic hs, logic vs, logic bl, logic sn);
    pix_t c, q;
    c = pix(n, hv, hf, hsw, hb, vv, vf, vsw, vb);
    chk({p, "col"}, 32'(col), c.col);
    chk({p, "row"}, 32'(row), c.row);
    chk({p, "video_on"}, 32'(von), 32'(c.von));
    chk({p, "frame_start"}, 32'(fs), 32'(c.fs));
    chk({p, "sync_n"}, 32'(sn), 0);
    if (n == 0) begin
      chk({p, "rst_r"}, 32'(r), 0);
      chk({p, "rst_g"}, 32'(g), 0);
      chk({p, "rst_b"}, 32'(b), 0);
      chk({p, "rst_hs"}, 32'(hs), 1);
      chk({p, "rst_vs"}, 32'(vs), 1);
      chk({p, "rst_blank_n"}, 32'(bl), 0);
    end else begin
      q = pix(n - 1, hv, hf, hsw, hb, vv, vf, vsw, vb);
      chk({p, "r"}, 32'(r), q.von ? 32'(pr) : 0);
      chk({p, "g"}, 32'(g), q.von ? 32'(pg) : 0);
      chk({p, "b"}, 32'(b), q.von ? 32'(pb) : 0);
      chk({p, "hs"}, 32'(hs), 32'(q.hs));
      chk({p, "vs"}, 32'(vs), 32'(q.vs));
      chk({p, "blank_n"}, 32'(bl), 32'(q.von));
    end
  endtask

  task automatic check_all();
    check_dut("s_", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
              if_s.col, if_s.row, if_s.video_on, if_s.frame_start,
              if_s.VGA_R, if_s.VGA_G, if_s.VGA_B,
              if_s.VGA_HS, if_s.VGA_VS, if_s.VGA_BLANK_N,
              if_s.VGA_SYNC_N);
    check_dut("d_", DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB,
              if_d.col, if_d.row, if_d.video_on, if_d.frame_start,
              if_d.VGA_R, if_d.VGA_G, if_d.VGA_B,
              if_d.VGA_HS, if_d.VGA_VS, if_d.VGA_BLANK_N,
              if_d.VGA_SYNC_N);
    if (if_s.frame_start) fs_cnt++;
    if (!if_s.VGA_VS) vs_run++;
    else if (vs_run != 0) begin
      chk("vs_low_run", vs_run, SVS * SHT);
      vs_runs++;
      vs_run = 0;
    end
    if (!if_d.VGA_HS) hs_run++;
    else if (hs_run != 0) begin
      chk("hs_low_run", hs_run, DHS);
      hs_run = 0;
    end
  endtask

  task automatic drive();
    logic [7:0] r, g, b;
    if ($urandom_range(3) == 0) begin
      r = 8'hB8; g = 8'hB8; b = 8'hB8;
    end else begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    end
    if_s.rgb_r = r; if_s.rgb_g = g; if_s.rgb_b = b;
    if_d.rgb_r = r; if_d.rgb_g = g; if_d.rgb_b = b;
    pr = r; pg = g; pb = b;
  endtask

  task automatic run(int k);
    repeat (k) begin
      check_all();
      drive();
      @(posedge clk_25mhz);
      n++;
      @(negedge clk_25mhz);
    end
  endtask

  task automatic check_reset_now(string p, logic [9:0] col,
                                 logic [9:0] row, logic [7:0] r,
                                 logic hs, logic vs, logic bl);
    chk({p, "arst_col"}, 32'(col), 0);
    chk({p, "arst_row"}, 32'(row), 0);
    chk({p, "arst_r"}, 32'(r), 0);
    chk({p, "arst_hs"}, 32'(hs), 1);
    chk({p, "arst_vs"}, 32'(vs), 1);
    chk({p, "arst_blank_n"}, 32'(bl), 0);
  endtask

  task automatic release_reset();
    @(negedge clk_25mhz);
    rst = 1'b0;
    n = 0;
    fs_cnt = 0;
    vs_run = 0;
    hs_run = 0;
    vs_runs = 0;
  endtask

  initial begin
    if_s.rgb_r = '0; if_s.rgb_g = '0; if_s.rgb_b = '0;
    if_d.rgb_r = '0; if_d.rgb_g = '0; if_d.rgb_b = '0;
    repeat (3) @(posedge clk_25mhz);
    #1;
    check_reset_now("s_", if_s.col, if_s.row, if_s.VGA_R,
                    if_s.VGA_HS, if_s.VGA_VS, if_s.VGA_BLANK_N);
    release_reset();

    run(SFT);
    chk("frame_start_count", fs_cnt, 1);
    chk("vs_run_count", vs_runs, 1);

    run(10 * SHT + 32);
    #2;
    rst = 1'b1;
    #1;
    check_reset_now("s_", if_s.col, if_s.row, if_s.VGA_R,
                    if_s.VGA_HS, if_s.VGA_VS, if_s.VGA_BLANK_N);
    check_reset_now("d_", if_d.col, if_d.row, if_d.VGA_R,
                    if_d.VGA_HS, if_d.VGA_VS, if_d.VGA_BLANK_N);
    repeat (3) @(posedge clk_25mhz);
    release_reset();

    run(SFT + 1);
    chk("frame_start_count2", fs_cnt, 2);
    chk("vs_run_count2", vs_runs, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
